hpdl1414_bus_sniffer: RTL

//  Reads the HPDL-1414 display bus: watches D[6:0], A[1:0] and the four active-low WR strobes.
//  On each completed write cycle it captures an event {position, character}.
//  The event goes into a small FIFO and is sent out as a 2-byte 8N1 UART frame.

---
 rtl/hpdl1414_pkg.sv | 26 ++
 rtl/uart_tx_byte.sv | 56 +++++
 rtl/hpdl1414_bus_sniffer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/hpdl1414_pkg.sv
// Shared types and helpers for the HPDL-1414 bus sniffer.
package hpdl1414_pkg;

  localparam logic [7:0] HDR_MARK = 8'h80;

  typedef struct packed {
    logic [3:0] pos;
    logic [6:0] chr;
  } hpdl_evt_t;

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DAT} tx_state_t;

  // Baud divisor, truncated.
  function automatic int unsigned div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

  // Index of the lowest-numbered active-low strobe.
  function automatic logic [1:0] low_idx(input logic [3:0] wr_n);
    if (!wr_n[0])      return 2'd0;
    else if (!wr_n[1]) return 2'd1;
    else if (!wr_n[2]) return 2'd2;
    else               return 2'd3;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// One 8N1 byte transmitter. A new start is accepted in the last cycle of the
// stop bit (done high), so consecutive bytes follow each other with no gap.
module uart_tx_byte #(
  parameter int DIV = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       done,
  output logic       tx
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    sh;
  logic          active;
  logic          bit_end;

  assign bit_end = (baud_cnt == CW'(DIV - 1));
  assign done    = active && bit_end && (bit_cnt == 4'd9);

  // Bit/baud sequencing; tx is registered so it changes only on clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      sh       <= '1;
    end else if (start && (!active || done)) begin
      active   <= 1'b1;
      tx       <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      sh       <= {1'b1, data};
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          active <= 1'b0;
          tx     <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          tx      <= sh[0];
          sh      <= {1'b1, sh[8:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hpdl1414_bus_sniffer.sv
// HPDL-1414 bus sniffer: synchronises the display bus, turns each completed
// write into a {pos, chr} event, queues it and sends it as a 2-byte UART frame.
module hpdl1414_bus_sniffer
  import hpdl1414_pkg::*;
#(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] hpdl_d,
  input  logic [1:0] hpdl_a,
  input  logic [3:0] hpdl_wr_n,
  output logic       uart_tx,
  output logic       evt_stb,
  output logic       collision,
  output logic       overflow,
  output logic       busy
);

  localparam int DIV = int'(div(CLK_HZ, BAUD));
  localparam int AW  = $clog2(FIFO_DEPTH);

  logic [6:0] d_s1, d_s2, lat_d;
  logic [1:0] a_s1, a_s2, lat_a;
  logic [3:0] wr_s1, wr_s2, wr_prev, lat_wr;
  logic       wr_done;
  hpdl_evt_t  new_evt, head;

  hpdl_evt_t  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, push_ok, pop;

  tx_state_t  state;
  logic [6:0] cur_chr;
  logic       tx_start, tx_done;
  logic [7:0] tx_data;

  // Two-flop synchronisers; the strobes idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_s1 <= '0;  d_s2 <= '0;
      a_s1 <= '0;  a_s2 <= '0;
      wr_s1 <= 4'hF; wr_s2 <= 4'hF;
    end else begin
      d_s1 <= hpdl_d;    d_s2 <= d_s1;
      a_s1 <= hpdl_a;    a_s2 <= a_s1;
      wr_s1 <= hpdl_wr_n; wr_s2 <= wr_s1;
    end
  end

  // Hold the bus as seen on the last cycle any strobe was low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_d <= '0; lat_a <= '0; lat_wr <= 4'hF; wr_prev <= 4'hF;
    end else begin
      wr_prev <= wr_s2;
      if (wr_s2 != 4'hF) begin
        lat_d <= d_s2; lat_a <= a_s2; lat_wr <= wr_s2;
      end
    end
  end

  assign wr_done = (wr_s2 == 4'hF) && (wr_prev != 4'hF);
  assign new_evt = {low_idx(lat_wr), lat_a, lat_d};

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign head    = mem[rd_ptr];
  assign pop     = !empty && ((state == ST_IDLE) || (state == ST_DAT && tx_done));
  assign push_ok = wr_done && (!full || pop);

  // FIFO storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= new_evt;
  end

  // FIFO pointers, event strobe and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0; rd_ptr <= '0; count <= '0;
      evt_stb <= 1'b0; collision <= 1'b0; overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      evt_stb <= push_ok;
      if (wr_done && ($countones(~lat_wr) > 1)) collision <= 1'b1;
      if (wr_done && full && !pop)              overflow  <= 1'b1;
    end
  end

  assign tx_start = pop || (state == ST_HDR && tx_done);
  assign tx_data  = (state == ST_HDR) ? {1'b0, cur_chr} : (HDR_MARK | {4'h0, head.pos});

  // Frame sequencer: header byte then data byte, chaining straight into the next event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cur_chr <= '0;
    end else begin
      case (state)
        ST_IDLE: if (pop) begin
          state   <= ST_HDR;
          cur_chr <= head.chr;
        end
        ST_HDR: if (tx_done) state <= ST_DAT;
        ST_DAT: if (tx_done) begin
          if (pop) begin
            state   <= ST_HDR;
            cur_chr <= head.chr;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = !empty || (state != ST_IDLE);

  uart_tx_byte #(.DIV(DIV)) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .start (tx_start),
    .data  (tx_data),
    .done  (tx_done),
    .tx    (uart_tx)
  );

endmodule
